rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single combinational instruction ROM read port between two requesters:
//  instruction fetch (IF) and data read (DR, constant loads from ROM).
//  Arbitrates per cycle, drives the ROM byte address, and registers the returned word.
//  Presents a valid/ready response to the granted requester. Sits between the PC/fetch
//  stage, the load path and the ROM instance.
// PARAMETERS
//  ADDR_W        4   byte-address width (16-byte ROM)
//  DATA_W        32  ROM word width
//  STARVE_LIMIT  3   consecutive IF losses before IF is forced to win (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  if_req     in   1       IF read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  IF byte address
//  if_gnt     out  1       IF request accepted this cycle (combinational)
//  if_rvalid  out  1       IF response word valid
//  if_rdata   out  DATA_W  IF response word
//  if_rready  in   1       IF consumes response
//  dr_req     in   1       DR read request; held with dr_addr until dr_gnt
//  dr_addr    in   ADDR_W  DR byte address
//  dr_gnt     out  1       DR request accepted this cycle (combinational)
//  dr_rvalid  out  1       DR response word valid
//  dr_rdata   out  DATA_W  DR response word
//  dr_rready  in   1       DR consumes response
//  rom_addr   out  ADDR_W  byte address to ROM; 0 when no grant
//  rom_data   in   DATA_W  ROM word (combinational from rom_addr)
// BEHAVIOUR
//  - Reset (async): state IDLE, all gnt/rvalid 0, rdata regs 0, owner=IF, starve_cnt 0.
//  - FSM: IDLE (no response held) / RESP (response held for owner).
//  - Grant window: state IDLE, or RESP with owner's rready=1 (back-to-back, 1 word/cycle).
//    No grants otherwise; RESP with rready=0 holds rvalid/rdata stable.
//  - Priority in grant window: DR wins, except IF wins when starve_cnt==STARVE_LIMIT.
//    Single requester always wins. At most one gnt per cycle.
//  - On grant: rom_addr = granted addr same cycle; rom_data captured at that clock edge
//    into the owner's rdata; owner's rvalid=1 next cycle -> latency 1 cycle req->rvalid.
//  - Transitions: grant -> RESP (owner updated); RESP & rready & no grant -> IDLE;
//    RESP & rready & grant -> RESP with new owner/data; RESP & !rready -> RESP.
//  - Only the owner's rvalid is 1; the other requester's rvalid is 0; rdata of the
//    non-owner holds its last value.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) each grant-window cycle with if_req=1
//    and DR granted; cleared when IF is granted or if_req=0.
//  - Address: ROM returns the aligned word {addr[ADDR_W-1:2],2'b00}; low bits only
//    matter for the error check below.
//  - Reset asserted mid-response: pending response dropped, no rvalid after release.
// CONFIGURATION
//  ROM_ARB_MISALIGN_ERR_EN defined: each requester gets an extra output
//   if_err/dr_err (1 bit, reset 0), valid with rvalid; set when granted addr[1:0]!=0;
//   rdata then returns 0 instead of ROM data.
//  Not defined: no err ports; misaligned addresses silently return the aligned word.
// TESTING
//  1 IF alone: if_req, if_addr=4'h4, rready=1 -> if_gnt same cycle, rom_addr=4'h4,
//    next cycle if_rvalid=1, if_rdata=ROM bytes 7..4.
//  2 Both request every cycle, rready=1, STARVE_LIMIT=3 -> grant order DR,DR,DR,IF,
//    repeat; starve_cnt back to 0 after the IF grant.
//  3 DR granted, dr_rready=0 for 3 cycles -> dr_rvalid/dr_rdata stable, no gnt, rom_addr=0;
//    dr_rready=1 with if_req -> if_gnt same cycle, if_rvalid next cycle.
//  4 rst_n low in RESP -> rvalid 0 immediately, state IDLE; after release no stale rvalid.
//  5 MISALIGN_ERR_EN: dr_addr=4'h9 -> dr_rvalid=1, dr_err=1, dr_rdata=0; without
//    macro -> dr_rdata = ROM bytes 11..8.
//  6 Back-to-back IF reads 0,4,8,C with rready=1 -> 4 rvalid beats on consecutive cycles.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single combinational instruction-ROM read port between the
//   instruction-fetch requester (IF) and the constant-load data-read requester
//   (DR). One request is accepted per cycle. The accepted address drives the ROM
//   in the same cycle, and the returned word is registered into the owner's
//   response register. The response is presented with valid/ready.
//
//   Optional build macro: ROM_ARB_MISALIGN_ERR_EN
//     When this macro is defined, the if_err/dr_err outputs exist. A granted
//     address with addr[1:0] != 0 sets the owner's err flag and returns 0 data.
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   if_req/if_addr/if_gnt       IF request, byte address, same-cycle accept
//   if_rvalid/if_rdata/if_rready IF response handshake
//   dr_req/dr_addr/dr_gnt       DR request, byte address, same-cycle accept
//   dr_rvalid/dr_rdata/dr_rready DR response handshake
//   if_err/dr_err               misalignment flag, valid with rvalid (macro only)
//   rom_addr                    byte address to ROM, 0 when nothing is granted
//   rom_data                    ROM word, combinational from rom_addr
module rom_port_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              if_rready,
    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_gnt,
    output logic              dr_rvalid,
    output logic [DATA_W-1:0] dr_rdata,
    input  logic              dr_rready,
`ifdef ROM_ARB_MISALIGN_ERR_EN
    output logic              if_err,
    output logic              dr_err,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, RESP} state_t;

    state_t             state;
    logic               owner_dr;      // 0: IF owns the held response, 1: DR owns it
    logic [CNT_W-1:0]   starve_cnt;

    logic               grant_window;
    logic               force_if;
    logic [ADDR_W-1:0]  gnt_addr_p0;
    logic [DATA_W-1:0]  cap_data_p0;
    logic               cap_err_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(STARVE_LIMIT))
            return v;
        else
            return v + 1'b1;
    endfunction

    // Stage 0: arbitration and ROM address, all combinational in the request cycle
    always_comb begin
        // A held response must be consumed by its owner before the port is reused.
        grant_window = (state == IDLE) || (owner_dr ? dr_rready : if_rready);
        force_if     = (starve_cnt == CNT_W'(STARVE_LIMIT));
        dr_gnt       = grant_window && dr_req && !(if_req && force_if);
        if_gnt       = grant_window && if_req && !dr_gnt;
        gnt_addr_p0  = if_gnt ? if_addr : (dr_gnt ? dr_addr : '0);
        rom_addr     = gnt_addr_p0;
`ifdef ROM_ARB_MISALIGN_ERR_EN
        cap_err_p0   = (gnt_addr_p0[1:0] != 2'b00);
        cap_data_p0  = cap_err_p0 ? '0 : rom_data;
`else
        // The ROM ignores the low address bits, so an unaligned address
        // returns the aligned word.
        cap_err_p0   = 1'b0;
        cap_data_p0  = rom_data;
`endif
    end

    // Stage 1: registered response for the owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_dr   <= 1'b0;
            if_rvalid  <= 1'b0;
            dr_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dr_rdata   <= '0;
            starve_cnt <= '0;
`ifdef ROM_ARB_MISALIGN_ERR_EN
            if_err     <= 1'b0;
            dr_err     <= 1'b0;
`endif
        end else begin
            if (if_gnt) begin
                state     <= RESP;
                owner_dr  <= 1'b0;
                if_rvalid <= 1'b1;
                dr_rvalid <= 1'b0;
                if_rdata  <= cap_data_p0;
`ifdef ROM_ARB_MISALIGN_ERR_EN
                if_err    <= cap_err_p0;
`endif
            end else if (dr_gnt) begin
                state     <= RESP;
                owner_dr  <= 1'b1;
                if_rvalid <= 1'b0;
                dr_rvalid <= 1'b1;
                dr_rdata  <= cap_data_p0;
`ifdef ROM_ARB_MISALIGN_ERR_EN
                dr_err    <= cap_err_p0;
`endif
            end else if (state == RESP && grant_window) begin
                // The owner consumed its word and nobody is waiting.
                state     <= IDLE;
                if_rvalid <= 1'b0;
                dr_rvalid <= 1'b0;
            end

            // IF losses are counted only while IF is actually waiting.
            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (dr_gnt)
                starve_cnt <= sat_inc(starve_cnt);
        end
    end

`ifndef ROM_ARB_MISALIGN_ERR_EN
    logic unused_cap_err;
    assign unused_cap_err = cap_err_p0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dr_req, if_rready, dr_rready;
    logic [3:0]  if_addr, dr_addr;
    logic        if_gnt, dr_gnt, if_rvalid, dr_rvalid;
    logic [31:0] if_rdata, dr_rdata;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
`ifdef ROM_ARB_MISALIGN_ERR_EN
    logic        if_err, dr_err;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: the held response, as seen by the requesters
    logic        m_busy;
    logic        m_owner_dr;
    logic [31:0] m_if_data, m_dr_data;
    logic        m_if_err, m_dr_err;
    int          m_starve;

    // Expected grants and observed DUT outputs from the latest cycle
    logic        e_if_g, e_dr_g;
    logic        o_if_g, o_dr_g, o_if_v, o_dr_v;
    logic [31:0] o_if_d, o_dr_d;
    logic [3:0]  o_addr;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(4), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rready(if_rready),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt),
        .dr_rvalid(dr_rvalid), .dr_rdata(dr_rdata), .dr_rready(dr_rready),
`ifdef ROM_ARB_MISALIGN_ERR_EN
        .if_err(if_err), .dr_err(dr_err),
`endif
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // ROM contents: byte i holds 8'hA0 + i, and words are little-endian.
    function automatic logic [7:0] rom_byte(input int i);
        return 8'(8'hA0 + i);
    endfunction

    function automatic logic [31:0] rom_word(input logic [3:0] a);
        int b;
        b = int'(a) & 32'hC;
        return {rom_byte(b + 3), rom_byte(b + 2), rom_byte(b + 1), rom_byte(b)};
    endfunction

    assign rom_data = rom_word(rom_addr);

    function automatic logic [31:0] exp_word(input logic [3:0] a);
`ifdef ROM_ARB_MISALIGN_ERR_EN
        if (a[1:0] != 2'b00) return 32'h0;
`endif
        return rom_word(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_dr = 0; m_if_data = 0; m_dr_data = 0;
        m_if_err = 0; m_dr_err = 0; m_starve = 0;
    endtask

    // Inputs must already be applied. This task checks at the negedge,
    // advances the model, and returns 1 time unit after the next posedge.
    task automatic cycle();
        logic win;
        logic [3:0] ea;
        @(negedge clk);
        win    = !m_busy || (m_owner_dr ? dr_rready : if_rready);
        e_dr_g = win && dr_req && !(if_req && m_starve == LIMIT);
        e_if_g = win && if_req && !e_dr_g;
        ea     = e_if_g ? if_addr : (e_dr_g ? dr_addr : 4'h0);
        o_if_g = if_gnt; o_dr_g = dr_gnt; o_if_v = if_rvalid; o_dr_v = dr_rvalid;
        o_if_d = if_rdata; o_dr_d = dr_rdata; o_addr = rom_addr;
        chk("if_gnt",    {31'b0, if_gnt},    {31'b0, e_if_g});
        chk("dr_gnt",    {31'b0, dr_gnt},    {31'b0, e_dr_g});
        chk("rom_addr",  {28'b0, rom_addr},  {28'b0, ea});
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, m_busy && !m_owner_dr});
        chk("dr_rvalid", {31'b0, dr_rvalid}, {31'b0, m_busy && m_owner_dr});
        chk("if_rdata",  if_rdata, m_if_data);
        chk("dr_rdata",  dr_rdata, m_dr_data);
`ifdef ROM_ARB_MISALIGN_ERR_EN
        chk("if_err", {31'b0, if_err}, {31'b0, m_if_err});
        chk("dr_err", {31'b0, dr_err}, {31'b0, m_dr_err});
`endif
        if (e_if_g) begin
            m_busy = 1; m_owner_dr = 0; m_if_data = exp_word(if_addr);
            m_if_err = (if_addr[1:0] != 2'b00);
        end else if (e_dr_g) begin
            m_busy = 1; m_owner_dr = 1; m_dr_data = exp_word(dr_addr);
            m_dr_err = (dr_addr[1:0] != 2'b00);
        end else if (m_busy && win) begin
            m_busy = 0;
        end
        if (!if_req || e_if_g) m_starve = 0;
        else if (e_dr_g && m_starve < LIMIT) m_starve++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] pat;
        rst_n = 0; if_req = 0; dr_req = 0; if_rready = 1; dr_rready = 1;
        if_addr = 0; dr_addr = 0;
        model_reset();
        #12;
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("rst_dr_rvalid", {31'b0, dr_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dr_rdata", dr_rdata, 32'd0);
        chk("rst_rom_addr", {28'b0, rom_addr}, 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // A single IF request is accepted and returns the word at 4 one cycle later.
        if_req = 1; if_addr = 4'h4;
        cycle();
        chk("t1_if_gnt", {31'b0, o_if_g}, 32'd1);
        chk("t1_rom_addr", {28'b0, o_addr}, 32'd4);
        if_req = 0;
        cycle();
        chk("t1_if_rvalid", {31'b0, o_if_v}, 32'd1);
        chk("t1_if_rdata", o_if_d, 32'hA7A6A5A4);

        // When both requesters are always present, grants follow DR,DR,DR,IF and repeat.
        if_req = 1; dr_req = 1; if_addr = 4'h0; dr_addr = 4'hC;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t2_dr_gnt", {31'b0, o_dr_g}, {31'b0, (i % 4) != 3});
            chk("t2_if_gnt", {31'b0, o_if_g}, {31'b0, (i % 4) == 3});
        end
        if_req = 0; dr_req = 0;
        cycle();

        // The held DR response stays stable while DR is not ready.
        dr_req = 1; dr_addr = 4'h8; dr_rready = 0;
        cycle();
        dr_req = 0; if_req = 1; if_addr = 4'hC;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_hold_gnt", {30'b0, o_if_g, o_dr_g}, 32'd0);
            chk("t3_hold_addr", {28'b0, o_addr}, 32'd0);
            chk("t3_hold_valid", {31'b0, o_dr_v}, 32'd1);
            chk("t3_hold_data", o_dr_d, 32'hABAAA9A8);
        end
        dr_rready = 1;
        cycle();
        chk("t3_if_gnt", {31'b0, o_if_g}, 32'd1);
        if_req = 0;
        cycle();
        chk("t3_if_rvalid", {31'b0, o_if_v}, 32'd1);
        chk("t3_dr_rvalid", {31'b0, o_dr_v}, 32'd0);
        chk("t3_if_rdata", o_if_d, 32'hAFAEADAC);

        // A misaligned DR address returns either the aligned word or an error.
        dr_req = 1; dr_addr = 4'h9;
        cycle();
        dr_req = 0;
        cycle();
        chk("t5_dr_rvalid", {31'b0, o_dr_v}, 32'd1);
`ifdef ROM_ARB_MISALIGN_ERR_EN
        chk("t5_dr_rdata", o_dr_d, 32'h0);
        chk("t5_dr_err", {31'b0, dr_err}, 32'd1);
`else
        chk("t5_dr_rdata", o_dr_d, 32'hABAAA9A8);
`endif

        // Back-to-back IF reads produce one beat per cycle.
        if_req = 1; if_addr = 4'h0;
        cycle();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) if_req = 0;
            else if_addr = 4'(i * 4);
            cycle();
            chk("t6_if_rvalid", {31'b0, o_if_v}, 32'd1);
            chk("t6_if_rdata", o_if_d, rom_word(4'((i - 1) * 4)));
        end

        // Asserting reset in the middle of a response drops it immediately.
        dr_req = 1; dr_addr = 4'h4; dr_rready = 0;
        cycle();
        dr_req = 0;
        #2 rst_n = 0;
        #1;
        chk("t4_dr_rvalid", {31'b0, dr_rvalid}, 32'd0);
        chk("t4_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("t4_dr_rdata", dr_rdata, 32'd0);
        model_reset();
        @(negedge clk); rst_n = 1; dr_rready = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_no_stale", {30'b0, o_if_v, o_dr_v}, 32'd0);
        end

        // Random traffic: each request is held until it is granted.
        for (int n = 0; n < 400; n++) begin
            if (!if_req || e_if_g) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 4'($urandom_range(0, 15));
            end
            if (!dr_req || e_dr_g) begin
                dr_req  = ($urandom_range(0, 2) != 0);
                dr_addr = 4'($urandom_range(0, 15));
            end
            pat = 2'($urandom_range(0, 3));
            if_rready = (pat != 0);
            dr_rready = (pat != 1);
            e_if_g = 0; e_dr_g = 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
